// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with bounded bursts and an occupancy tracker
// that keeps writes out of a full FIFO.
module fifo_wr_arbiter #(
    parameter int NREQ  = 3,
    parameter int DW    = 3,
    parameter int DEPTH = 5,
    parameter int BURST = 2,
    localparam int LW   = $clog2(DEPTH + 1),
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW   = $clog2(BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din,
    output logic [NREQ-1:0]      ack,
    input  logic                 fifo_rd,
    output logic                 fifo_wr,
    output logic [DW-1:0]        fifo_din,
    output logic [LW-1:0]        level,
    output logic                 full,
    output logic                 empty,
    output logic                 rd_err
);

    logic [OW-1:0] owner;
    logic [BW-1:0] bcnt;
    logic          held;
    logic [OW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          eligible;
    logic          dec;

    function automatic logic [OW-1:0] rr_next(input logic [OW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NREQ;
        return OW'(s);
    endfunction

    assign eligible = (level < LW'(DEPTH));

    // held stays low until the first grant after reset, so the reset owner
    // (NREQ-1) never continues a burst and requester 0 wins first.
    always_comb begin
        gnt_idx = owner;
        gnt_vld = 1'b0;
        if (held && req[owner] && (bcnt < BW'(BURST))) begin
            gnt_vld = 1'b1;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!gnt_vld && req[rr_next(owner, k)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_next(owner, k);
                end
            end
        end
        if (!eligible || !rst) begin
            gnt_vld = 1'b0;
        end
    end

    assign ack = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= OW'(NREQ - 1);
            bcnt  <= BW'(1);
            held  <= 1'b0;
        end else if (gnt_vld) begin
            held <= 1'b1;
            if (held && (gnt_idx == owner) && (bcnt < BW'(BURST))) begin
                bcnt <= bcnt + BW'(1);
            end else begin
                owner <= gnt_idx;
                bcnt  <= BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_wr  <= 1'b0;
            fifo_din <= '0;
        end else begin
            fifo_wr <= gnt_vld;
            if (gnt_vld) begin
                fifo_din <= din[gnt_idx*DW +: DW];
            end
        end
    end

    assign dec = fifo_rd && (level != '0);

    // An accepted write and a read in the same cycle cancel each other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level  <= '0;
            rd_err <= 1'b0;
        end else begin
            if (gnt_vld && !dec) begin
                level <= level + LW'(1);
            end else if (!gnt_vld && dec) begin
                level <= level - LW'(1);
            end
            if (fifo_rd && (level == '0)) begin
                rd_err <= 1'b1;
            end
        end
    end

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=3, DW=3, DEPTH=5, BURST=2).
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [8:0] din;
    logic [2:0] ack;
    logic       fifo_rd;
    logic       fifo_wr;
    logic [2:0] fifo_din;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       rd_err;

    int checks = 0;
    int passed = 0;

    logic [2:0] data [3] = '{3'd5, 3'd3, 3'd6};

    assign din = {data[2], data[1], data[0]};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(3), .DW(3), .DEPTH(5), .BURST(2)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack),
        .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .level(level), .full(full), .empty(empty), .rd_err(rd_err)
    );

    task automatic test_reset;
        rst = 1'b1; req = 3'b111; fifo_rd = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ack !== 3'b000) $display("[TB] FAIL reset_ack: got %b want 000", ack); else passed++;
        checks++; if (fifo_wr !== 1'b0) $display("[TB] FAIL reset_wr: got %b want 0", fifo_wr); else passed++;
        checks++; if (fifo_din !== 3'd0) $display("[TB] FAIL reset_din: got %0d want 0", fifo_din); else passed++;
        checks++; if (level !== 3'd0) $display("[TB] FAIL reset_level: got %0d want 0", level); else passed++;
        checks++; if (empty !== 1'b1 || full !== 1'b0) $display("[TB] FAIL reset_flags: empty %b full %b want 1 0", empty, full); else passed++;
        checks++; if (rd_err !== 1'b0) $display("[TB] FAIL reset_rd_err: got %b want 0", rd_err); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (ack !== 3'b001) $display("[TB] FAIL release_ack: got %b want 001", ack); else passed++;
        req = 3'b000;
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_ack [8] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
        int         exp_idx [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            req = 3'b111; fifo_rd = (s > 0);
            if (s > 0) begin
                checks++; if (fifo_wr !== 1'b1) $display("[TB] FAIL rr_wr[%0d]: got %b want 1", s, fifo_wr); else passed++;
                checks++; if (fifo_din !== data[exp_idx[s-1]]) $display("[TB] FAIL rr_din[%0d]: got %0d want %0d", s, fifo_din, data[exp_idx[s-1]]); else passed++;
                checks++; if (level !== 3'd1) $display("[TB] FAIL rr_level[%0d]: got %0d want 1", s, level); else passed++;
            end
            #1;
            checks++; if (ack !== exp_ack[s]) $display("[TB] FAIL rr_ack[%0d]: got %b want %b", s, ack, exp_ack[s]); else passed++;
        end
        @(negedge clk);
        req = 3'b000; fifo_rd = 1'b1;
        checks++; if (fifo_din !== data[0]) $display("[TB] FAIL rr_last_din: got %0d want %0d", fifo_din, data[0]); else passed++;
        @(negedge clk);
        fifo_rd = 1'b0;
        checks++; if (level !== 3'd0 || fifo_wr !== 1'b0) $display("[TB] FAIL rr_drain: level %0d wr %b want 0 0", level, fifo_wr); else passed++;
    endtask

    task automatic test_lone_requester;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            req = 3'b010; fifo_rd = (s > 0);
            if (s > 0) begin
                checks++; if (fifo_wr !== 1'b1 || fifo_din !== data[1]) $display("[TB] FAIL lone_wr[%0d]: wr %b din %0d want 1 %0d", s, fifo_wr, fifo_din, data[1]); else passed++;
                checks++; if (level !== 3'd1) $display("[TB] FAIL lone_level[%0d]: got %0d want 1", s, level); else passed++;
            end
            #1;
            checks++; if (ack !== 3'b010) $display("[TB] FAIL lone_ack[%0d]: got %b want 010", s, ack); else passed++;
        end
        @(negedge clk);
        req = 3'b000; fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        checks++; if (level !== 3'd0 || empty !== 1'b1) $display("[TB] FAIL lone_drain: level %0d empty %b want 0 1", level, empty); else passed++;
    endtask

    task automatic test_full_stall;
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            req = 3'b001; fifo_rd = 1'b0;
            checks++; if (level !== 3'((s < 5) ? s : 5)) $display("[TB] FAIL stall_level[%0d]: got %0d want %0d", s, level, (s < 5) ? s : 5); else passed++;
            checks++; if (full !== (s >= 5)) $display("[TB] FAIL stall_full[%0d]: got %b want %b", s, full, (s >= 5)); else passed++;
            #1;
            checks++; if (ack !== ((s < 5) ? 3'b001 : 3'b000)) $display("[TB] FAIL stall_ack[%0d]: got %b want %b", s, ack, (s < 5) ? 3'b001 : 3'b000); else passed++;
        end
        checks++; if (fifo_wr !== 1'b0) $display("[TB] FAIL stall_no_wr: got %b want 0", fifo_wr); else passed++;
        @(negedge clk);
        fifo_rd = 1'b1;
        #1;
        checks++; if (ack !== 3'b000) $display("[TB] FAIL stall_rd_same_cycle_ack: got %b want 000", ack); else passed++;
        @(negedge clk);
        fifo_rd = 1'b0;
        checks++; if (level !== 3'd4 || full !== 1'b0) $display("[TB] FAIL stall_after_rd: level %0d full %b want 4 0", level, full); else passed++;
        #1;
        checks++; if (ack !== 3'b001) $display("[TB] FAIL stall_ack_return: got %b want 001", ack); else passed++;
        @(negedge clk);
        req = 3'b000;
        checks++; if (level !== 3'd5 || fifo_wr !== 1'b1 || fifo_din !== data[0]) $display("[TB] FAIL stall_refill: level %0d wr %b din %0d want 5 1 %0d", level, fifo_wr, fifo_din, data[0]); else passed++;
    endtask

    task automatic test_simultaneous;
        @(negedge clk); fifo_rd = 1'b1;
        @(negedge clk); fifo_rd = 1'b1;
        @(negedge clk);
        checks++; if (level !== 3'd3) $display("[TB] FAIL simul_setup_level: got %0d want 3", level); else passed++;
        req = 3'b001; fifo_rd = 1'b1;
        #1;
        checks++; if (ack !== 3'b001) $display("[TB] FAIL simul_ack: got %b want 001", ack); else passed++;
        @(negedge clk);
        req = 3'b000; fifo_rd = 1'b1;
        checks++; if (level !== 3'd3) $display("[TB] FAIL simul_level: got %0d want 3", level); else passed++;
        checks++; if (fifo_wr !== 1'b1 || fifo_din !== data[0]) $display("[TB] FAIL simul_wr: wr %b din %0d want 1 %0d", fifo_wr, fifo_din, data[0]); else passed++;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        fifo_rd = 1'b0;
        checks++; if (level !== 3'd0 || empty !== 1'b1 || rd_err !== 1'b0) $display("[TB] FAIL simul_drain: level %0d empty %b rd_err %b want 0 1 0", level, empty, rd_err); else passed++;
    endtask

    task automatic test_underflow;
        @(negedge clk); fifo_rd = 1'b1;
        @(negedge clk); fifo_rd = 1'b0;
        checks++; if (level !== 3'd0 || rd_err !== 1'b1) $display("[TB] FAIL under_set: level %0d rd_err %b want 0 1", level, rd_err); else passed++;
        req = 3'b001;
        @(negedge clk);
        req = 3'b000; fifo_rd = 1'b1;
        checks++; if (level !== 3'd1 || rd_err !== 1'b1) $display("[TB] FAIL under_sticky_wr: level %0d rd_err %b want 1 1", level, rd_err); else passed++;
        @(negedge clk);
        fifo_rd = 1'b0;
        checks++; if (level !== 3'd0 || rd_err !== 1'b1) $display("[TB] FAIL under_sticky_rd: level %0d rd_err %b want 0 1", level, rd_err); else passed++;
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clk); req = 3'b001;
        @(negedge clk);
        checks++; if (fifo_wr !== 1'b1) $display("[TB] FAIL midrst_pre_wr: got %b want 1", fifo_wr); else passed++;
        #1 rst = 1'b0;
        #1;
        checks++; if (fifo_wr !== 1'b0 || ack !== 3'b000) $display("[TB] FAIL midrst_async: wr %b ack %b want 0 000", fifo_wr, ack); else passed++;
        checks++; if (level !== 3'd0 || rd_err !== 1'b0) $display("[TB] FAIL midrst_state: level %0d rd_err %b want 0 0", level, rd_err); else passed++;
        @(negedge clk);
        checks++; if (fifo_wr !== 1'b0 || level !== 3'd0) $display("[TB] FAIL midrst_hold: wr %b level %0d want 0 0", fifo_wr, level); else passed++;
        rst = 1'b1; req = 3'b000;
        @(negedge clk);
        checks++; if (fifo_wr !== 1'b0 || empty !== 1'b1) $display("[TB] FAIL midrst_release: wr %b empty %b want 0 1", fifo_wr, empty); else passed++;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_lone_requester;
        test_full_stall;
        test_simultaneous;
        test_underflow;
        test_reset_mid_burst;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter and occupancy tracker for the small 3-bit FIFO. NREQ producers compete for the single FIFO write port, and one producer is granted per cycle in round-robin order with a bounded burst. The block keeps its own occupancy count, so no write is issued into a full FIFO. It sits between the producer blocks and the FIFO write port, and runs on the FIFO's write clock domain.

## Interface
- NREQ, 3: number of requesters (2..4).
- DW, 3: data width.
- DEPTH, 5: FIFO depth; must match the FIFO instance.
- BURST, 2: maximum consecutive grants to one requester while others are waiting.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester valid; held with its data until accepted.
- din  in  NREQ*DW  packed data; requester i uses bits [i*DW +: DW].
- ack  out  NREQ  combinational ready, one-hot or zero; a transfer happens on an edge where req[i] and ack[i] are both 1.
- fifo_rd  in  1  pulse, one per word the consumer removes from the FIFO.
- fifo_wr  out  1  registered write strobe to the FIFO.
- fifo_din  out  DW  registered write data.
- level  out  3  occupancy count, 0..DEPTH (width = clog2(DEPTH+1)).
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- rd_err  out  1  sticky flag: fifo_rd seen while level == 0.

## Operation
- State: owner index (0..NREQ-1), burst count bcnt (1..BURST), level.
- Eligibility: a request may be granted only when level < DEPTH. When level == DEPTH, ack = 0 and owner and bcnt hold.
- Grant selection, evaluated every cycle:
  - If req[owner] = 1 and bcnt < BURST, the owner is granted.
  - Otherwise search round-robin starting at owner+1 (modulo NREQ), with owner checked last; the first requester found is granted.
- Grant takes effect on a handshake edge:
  - Same index as owner: bcnt increments.
  - Different index: owner takes the new index and bcnt = 1.
  - Owner re-granted after reaching BURST because no other requester is active: bcnt = 1.
  - No grant: state holds.
- On a handshake, on the next edge fifo_wr = 1 and fifo_din = din slice of the granted requester. Otherwise fifo_wr = 0 and fifo_din holds its value.
- level on each edge:
  - +1 on a handshake.
  - -1 on fifo_rd when level > 0.
  - Unchanged when both occur in the same cycle, or when neither occurs.
- fifo_rd with level == 0: level stays 0 and rd_err sets, staying set until reset.
- A simultaneous fifo_rd does not make a full FIFO eligible in that same cycle; eligibility uses the registered level.

## Timing
- ack is combinational from registered state and req. It has no latency: a requester with req high gets ack in the same cycle if it is selected.
- A write lands at the FIFO exactly 1 cycle after its handshake edge. level reflects the word at that same edge, one cycle ahead of the FIFO's own count.
- Sustained throughput is 1 word per cycle with no bubble on owner change.
- Reset (rst = 0, asynchronous):
  - Outputs: ack = 0 (forced while rst is low), fifo_wr = 0, fifo_din = 0, level = 0, empty = 1, full = 0, rd_err = 0.
  - State: owner = NREQ-1, so requester 0 has first priority; bcnt = 1.
- Reset asserted mid-burst drops any pending transfer: no fifo_wr is issued after rst falls. Release is synchronous to the next edge.

## Test plan
- Reset: hold rst = 0 with req = 3'b111. Required: ack = 0, fifo_wr = 0, level = 0, empty = 1. After release, the first ack is 3'b001.
- Round robin with burst: req = 3'b111 held, level drained by fifo_rd every cycle. Required grant order 0,0,1,1,2,2,0,... and fifo_din matching each sender's data one cycle later.
- Lone requester: req = 3'b010 only, with continuous reads. Required: ack[1] = 1 every cycle, bcnt recycles to 1, no bubbles.
- Full stall: req = 3'b001 with no reads, 5 writes. Required: level 1..5, full = 1, ack = 0 from the 6th cycle on. One fifo_rd gives level 4, and ack returns the following cycle.
- Simultaneous events: level = 3, handshake and fifo_rd in the same cycle. Required: level stays 3 and fifo_wr = 1 on the next cycle.
- Underflow: fifo_rd pulse at level 0. Required: level stays 0, rd_err = 1 and stays set through later traffic until rst.
